wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  Architectural integer register file: the consumer of the MEM/WB writeback interface
//  (wb_data / wb_reg_dest / wb_reg_write).
//  - Two combinational read ports for the decode stage.
//  - Write-through bypass, so a value written back is visible in the same cycle.
//  - Per-register busy scoreboard for long-latency producers; drives a decode stall.
//  - Exports a registered copy of a0 (x10) for test/debug observation.
// PARAMETERS
//  DATA_WIDTH  32  width of each register and of wb_data
//  ADDR_WIDTH  5   register index width; register count = 2**ADDR_WIDTH
//  A0_INDEX    10  index mirrored on the a0 output
// PORTS
//  clk           in   1           rising-edge clock
//  rst_n         in   1           asynchronous reset, active low
//  wb_reg_write  in   1           writeback enable
//  wb_reg_dest   in   ADDR_WIDTH  writeback destination index
//  wb_data       in   DATA_WIDTH  writeback data
//  rs1_addr      in   ADDR_WIDTH  read port 1 index
//  rs2_addr      in   ADDR_WIDTH  read port 2 index
//  rs1_data      out  DATA_WIDTH  read port 1 data (combinational)
//  rs2_data      out  DATA_WIDTH  read port 2 data (combinational)
//  issue_valid   in   1           long-latency op issued this cycle; marks issue_rd busy
//  issue_rd      in   ADDR_WIDTH  destination of the issued op
//  flush         in   1           pipeline flush; clears all busy bits
//  busy_stall    out  1           rs1 or rs2 awaits an outstanding producer (combinational)
//  a0            out  DATA_WIDTH  registered mirror of x[A0_INDEX]
// BEHAVIOUR
//  Reset (rst_n low, asynchronous):
//   - All registers = 0, all busy bits = 0, a0 = 0.
//   - Holds while low. First write is accepted on the first rising edge after deassertion.
//  Write:
//   - On posedge, if wb_reg_write && wb_reg_dest != 0, then x[wb_reg_dest] <= wb_data.
//   - Writes to x0 are dropped. x0 always reads 0.
//  Read:
//   - rsN_data = 0 if rsN_addr == 0.
//   - Otherwise wb_data if wb_reg_write && wb_reg_dest == rsN_addr (bypass).
//   - Otherwise x[rsN_addr].
//   - No latency. Both ports are independent and may address the same register.
//  a0:
//   - Updated on the same edge as the array, i.e. a0 always equals x[A0_INDEX] after the edge.
//   - A write to A0_INDEX is visible on a0 one cycle after wb_reg_write is sampled.
//  Scoreboard, one busy bit per register; bit 0 is never set:
//   - Set on posedge when issue_valid && issue_rd != 0.
//   - Cleared on posedge when wb_reg_write targets that index.
//   - Same edge, same index, set and clear together: set wins (a newer producer has issued).
//   - flush clears every bit on that edge and overrides a same-cycle issue_valid.
//   - Issue to an already-busy index leaves it busy. No counting; in-order writeback is guaranteed upstream.
//  busy_stall:
//   - Stall per port: busy[rsN] && rsN != 0 && !(wb_reg_write && wb_reg_dest == rsN).
//     The same-cycle writeback is satisfied through the bypass, so it does not stall.
//   - busy_stall = stall(rs1) | stall(rs2).
//   - busy_stall never depends on issue_valid in the same cycle. No combinational loop to decode.
//  Out-of-range behaviour: none; every ADDR_WIDTH value is a valid index.
// STRUCTURE
//  - Package pipeline_pkg: REG_ADDR_WIDTH = 5, XLEN = 32, REG_ZERO = 0, REG_A0 = 10,
//    typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t.
//  - One sub-module: reg_scoreboard (busy vector, set/clear/flush priority, per-port stall terms).
//  - Array, bypass muxes and the a0 mirror stay in wb_regfile.
// TESTING
//  1. Reset mid-run: write x5=0xDEADBEEF, pulse rst_n low off-edge
//     -> rs1_data(x5)=0, a0=0 and busy_stall=0, immediately and asynchronously.
//  2. x0 write: wb_reg_write=1, wb_reg_dest=0, wb_data=0x1234
//     -> rs1_addr=0 reads 0 during and after the edge.
//  3. Bypass: wb writes x7=0xA5A5A5A5 while rs1_addr=rs2_addr=7
//     -> both ports show 0xA5A5A5A5 in that cycle and retain it after the edge.
//  4. Scoreboard: issue_rd=3, then rs1_addr=3 -> busy_stall=1.
//     Cycle with wb write x3=0x42 -> busy_stall=0 and rs1_data=0x42. Next cycle busy_stall stays 0.
//  5. Priority: same edge issue_rd=4 and wb write x4 -> x4 still busy.
//     Then flush=1 with issue_valid=1, issue_rd=6 -> no bit busy, busy_stall=0 for rs=4 and rs=6.
//  6. a0 mirror: wb write x10=0x00000055 -> a0=0x55 one cycle later.
//     A write to x11 leaves a0 unchanged.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the register-index type used by the writeback
// register file and its scoreboard.
package pipeline_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int XLEN           = 32;
   localparam int REG_ZERO       = 0;
   localparam int REG_A0         = 10;

   typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for long-latency producers, plus the per-port decode
// stall terms that the same-cycle writeback bypass can satisfy.
module reg_scoreboard
   import pipeline_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic                  flush,
   input  logic                  wb_reg_write,
   input  logic [ADDR_WIDTH-1:0] wb_reg_dest,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic                  busy_stall
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   logic [NUM_REGS-1:0] busy_r;
   logic [NUM_REGS-1:0] busy_nxt_s;
   logic                stall_rs1_s;
   logic                stall_rs2_s;

   // Next busy vector: clear on writeback, then set on issue so a newer producer wins.
   always_comb begin
      busy_nxt_s = busy_r;
      if (flush) begin
         busy_nxt_s = {NUM_REGS{1'b0}};
      end else begin
         if (wb_reg_write) begin
            busy_nxt_s[wb_reg_dest] = 1'b0;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
         if (issue_valid && (issue_rd != ZERO_IDX)) begin
            busy_nxt_s[issue_rd] = 1'b1;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
      end
      busy_nxt_s[0] = 1'b0;
   end

   // Busy vector register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= {NUM_REGS{1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   // Stall terms; independent of issue_valid so decode never sees a loop.
   always_comb begin
      stall_rs1_s = busy_r[rs1_addr] && (rs1_addr != ZERO_IDX)
                    && !(wb_reg_write && (wb_reg_dest == rs1_addr));
      stall_rs2_s = busy_r[rs2_addr] && (rs2_addr != ZERO_IDX)
                    && !(wb_reg_write && (wb_reg_dest == rs2_addr));
   end

   assign busy_stall = stall_rs1_s | stall_rs2_s;

endmodule

// File: rtl/wb_regfile.sv
// Architectural integer register file fed by MEM/WB writeback: two bypassed
// read ports, a busy scoreboard driving decode stall, and a registered a0 mirror.
module wb_regfile
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int A0_INDEX   = REG_A0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wb_reg_write,
   input  logic [ADDR_WIDTH-1:0] wb_reg_dest,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic                  flush,
   output logic                  busy_stall,
   output logic [DATA_WIDTH-1:0] a0
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);
   localparam logic [ADDR_WIDTH-1:0] A0_IDX   = ADDR_WIDTH'(A0_INDEX);

   logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
   logic [DATA_WIDTH-1:0] a0_r;
   logic [DATA_WIDTH-1:0] rs1_data_s;
   logic [DATA_WIDTH-1:0] rs2_data_s;
   logic                  wr_en_s;

   assign wr_en_s = wb_reg_write && (wb_reg_dest != ZERO_IDX);

   // Register array; x0 writes are dropped by wr_en_s.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (wr_en_s) begin
         regs_r[wb_reg_dest] <= wb_data;
      end
   end

   // a0 mirror tracks the array value as it stands after each edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a0_r <= {DATA_WIDTH{1'b0}};
      end else if (wr_en_s && (wb_reg_dest == A0_IDX)) begin
         a0_r <= wb_data;
      end else begin
         a0_r <= regs_r[A0_IDX];
      end
   end

   // Read ports: x0 forced to zero, otherwise same-cycle writeback bypass.
   always_comb begin
      if (rs1_addr == ZERO_IDX) begin
         rs1_data_s = {DATA_WIDTH{1'b0}};
      end else if (wb_reg_write && (wb_reg_dest == rs1_addr)) begin
         rs1_data_s = wb_data;
      end else begin
         rs1_data_s = regs_r[rs1_addr];
      end
      if (rs2_addr == ZERO_IDX) begin
         rs2_data_s = {DATA_WIDTH{1'b0}};
      end else if (wb_reg_write && (wb_reg_dest == rs2_addr)) begin
         rs2_data_s = wb_data;
      end else begin
         rs2_data_s = regs_r[rs2_addr];
      end
   end

   assign rs1_data = rs1_data_s;
   assign rs2_data = rs2_data_s;
   assign a0       = a0_r;

   reg_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .flush        (flush),
      .wb_reg_write (wb_reg_write),
      .wb_reg_dest  (wb_reg_dest),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .busy_stall   (busy_stall)
   );

endmodule
